// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// inst_fetch_ctrl : walks a command stream in instruction memory and hands out
//                   decoded headers and 4-word argument beats.
// Revision 1.0
// ============================================================================
module inst_fetch_ctrl #(
    parameter int unsigned MEM_DEPTH = 43,
    parameter int unsigned MAX_ARGS  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  base_addr,
    output logic [31:0]  addr1,
    output logic [31:0]  addr2,
    input  logic [31:0]  read0,
    input  logic [31:0]  read1,
    input  logic [31:0]  read2,
    input  logic [31:0]  read3,
    input  logic [31:0]  read4,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_opcode,
    output logic [7:0]   cmd_imm,
    output logic [7:0]   cmd_argc,
    output logic         arg_valid,
    input  logic         arg_ready,
    output logic [127:0] arg_data,
    output logic [2:0]   arg_count,
    output logic         arg_last,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_ARGS  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] c_depth32  = 32'(MEM_DEPTH);
    localparam logic [32:0] c_depth33  = 33'(MEM_DEPTH);
    localparam logic [8:0]  c_max_args = 9'(MAX_ARGS);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ap_q, ap_d;
    logic [16:0] hdr_q, hdr_d;     // {has_args, field[15:8], opcode[7:0]}
    logic [7:0]  rem_q, rem_d;
    logic        error_q, error_d;

    logic [7:0]  hdr_argc;
    logic [2:0]  beat_cnt;
    logic        beat_last;
    logic [32:0] fetch_end;
    logic        fetch_bad;

    assign hdr_argc  = hdr_q[16] ? hdr_q[15:8] : 8'd0;
    assign beat_cnt  = (rem_q > 8'd4) ? 3'd4 : rem_q[2:0];
    assign beat_last = (rem_q <= 8'd4);

    // Widened so the last-argument bound cannot wrap.
    assign fetch_end = {1'b0, pc_q} + {25'd0, read0[15:8]};
    assign fetch_bad = (pc_q >= c_depth32) ||
                       (read0[31] && (({1'b0, read0[15:8]} > c_max_args) ||
                                      (fetch_end >= c_depth33)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            ap_q    <= 32'd0;
            hdr_q   <= 17'd0;
            rem_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ap_q    <= ap_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ap_d    = ap_q;
        hdr_d   = hdr_q;
        rem_d   = rem_q;
        error_d = error_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d    = base_addr;
                        error_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    hdr_d = {read0[31], read0[15:0]};
                    if (read0 == 32'd0) begin
                        state_d = S_DONE;
                    end else if (fetch_bad) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        if (hdr_argc != 8'd0) begin
                            ap_d    = pc_q + 32'd1;
                            rem_d   = hdr_argc;
                            state_d = S_ARGS;
                        end else begin
                            pc_d    = pc_q + 32'd1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_ARGS: begin
                    if (arg_ready) begin
                        ap_d  = ap_q + 32'd4;
                        rem_d = rem_q - {5'd0, beat_cnt};
                        if (beat_last) begin
                            pc_d    = pc_q + 32'd1 + {24'd0, hdr_argc};
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Payload outputs are zeroed outside their state so reset blanks every port.
    always_comb begin
        cmd_valid  = 1'b0;
        cmd_opcode = 8'd0;
        cmd_imm    = 8'd0;
        cmd_argc   = 8'd0;
        arg_valid  = 1'b0;
        arg_data   = 128'd0;
        arg_count  = 3'd0;
        arg_last   = 1'b0;
        case (state_q)
            S_CMD: begin
                cmd_valid  = 1'b1;
                cmd_opcode = hdr_q[7:0];
                cmd_imm    = hdr_q[16] ? 8'd0 : hdr_q[15:8];
                cmd_argc   = hdr_argc;
            end
            S_ARGS: begin
                arg_valid = 1'b1;
                arg_data  = {read1, read2, read3, read4};
                arg_count = beat_cnt;
                arg_last  = beat_last;
            end
            default: ;
        endcase
    end

    assign addr1 = pc_q;
    assign addr2 = ap_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_ctrl : directed scenarios with random argument data and random
//                      ready backpressure, checked against a command-stream model.
// Revision 1.0
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam int MEM_DEPTH = 43;
    localparam int MAX_ARGS  = 16;

    logic         clk = 1'b0;
    logic         rst_n, start, abort;
    logic [31:0]  base_addr, addr1, addr2;
    logic [31:0]  read0, read1, read2, read3, read4;
    logic         cmd_valid, cmd_ready, arg_valid, arg_ready, arg_last;
    logic [7:0]   cmd_opcode, cmd_imm, cmd_argc;
    logic [127:0] arg_data;
    logic [2:0]   arg_count;
    logic         busy, done, error;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.MEM_DEPTH(MEM_DEPTH), .MAX_ARGS(MAX_ARGS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .addr1(addr1), .addr2(addr2),
        .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_imm(cmd_imm), .cmd_argc(cmd_argc),
        .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
        .arg_count(arg_count), .arg_last(arg_last),
        .busy(busy), .done(done), .error(error)
    );

    logic [31:0] mem [0:63];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return (a < 32'd64) ? mem[a[5:0]] : 32'd0;
    endfunction

    always_comb begin
        read0 = memrd(addr1);
        read1 = memrd(addr2);
        read2 = memrd(addr2 + 32'd1);
        read3 = memrd(addr2 + 32'd2);
        read4 = memrd(addr2 + 32'd3);
    end

    typedef struct { logic [7:0] op; logic [7:0] imm; logic [7:0] argc; } cmd_t;
    typedef struct { logic [127:0] data; logic [127:0] mask; logic [2:0] cnt; logic last; } beat_t;

    cmd_t  cq[$];
    beat_t bq[$];
    bit    m_err;
    int    m_done_cyc;
    int    last_done_cyc;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Projection, 16-arg multmatrix, three colour/vertex pairs, terminator.
    task automatic load_image();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0] = 32'h0000_0110;
        mem[1] = 32'h8000_1011;
        for (int i = 2; i < 18; i++) mem[i] = $urandom;
        for (int p = 0; p < 3; p++) begin
            mem[18 + 8*p] = 32'h8000_0304;
            mem[22 + 8*p] = 32'h8000_0303;
            for (int j = 1; j < 4; j++) begin
                mem[18 + 8*p + j] = $urandom;
                mem[22 + 8*p + j] = $urandom;
            end
        end
        mem[42] = 32'd0;
    endtask

    // Walks memory by the header rules and lists the expected commands and beats.
    task automatic build_model(input int base);
        int pc, n, left;
        logic [31:0] h;
        cmd_t  c;
        beat_t b;
        cq.delete();
        bq.delete();
        m_err      = 1'b0;
        m_done_cyc = 2;
        pc         = base;
        for (int g = 0; g < 64; g++) begin
            h = memrd(32'(pc));
            if (h == 32'd0) break;
            n = h[31] ? int'(h[15:8]) : 0;
            if (pc >= MEM_DEPTH || (h[31] && (n > MAX_ARGS || pc + n >= MEM_DEPTH))) begin
                m_err = 1'b1;
                break;
            end
            c.op   = h[7:0];
            c.imm  = h[31] ? 8'd0 : h[15:8];
            c.argc = 8'(n);
            cq.push_back(c);
            m_done_cyc += 2 + (n + 3) / 4;
            for (int k = 0; 4*k < n; k++) begin
                left   = n - 4*k;
                b.cnt  = 3'((left > 4) ? 4 : left);
                b.last = (left <= 4);
                b.data = '0;
                b.mask = '0;
                for (int j = 0; j < 4; j++) begin
                    if (j < left) begin
                        b.data[127 - 32*j -: 32] = memrd(32'(pc + 1 + 4*k + j));
                        b.mask[127 - 32*j -: 32] = 32'hFFFF_FFFF;
                    end
                end
                bq.push_back(b);
            end
            pc += 1 + n;
        end
    endtask

    task automatic run_stream(input int base, input bit rnd, input int abort_beat);
        int cyc, nbeat, first_cmd;
        bit finished, go_abort;
        build_model(base);
        @(negedge clk);
        base_addr = 32'(base);
        start     = 1'b1;
        cmd_ready = 1'b1;
        arg_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        nbeat     = 0;
        first_cmd = 0;
        finished  = 1'b0;
        check("start_clears_error", error, 0);
        while (!finished && cyc < 1000) begin
            go_abort = 1'b0;
            check("valid_exclusive", cmd_valid & arg_valid, 0);
            if (cmd_valid) begin
                if (first_cmd == 0) first_cmd = cyc;
                check("cmd_expected", cq.size() > 0, 1);
                if (cq.size() > 0) begin
                    check("cmd_opcode", cmd_opcode, cq[0].op);
                    check("cmd_imm", cmd_imm, cq[0].imm);
                    check("cmd_argc", cmd_argc, cq[0].argc);
                end
            end
            if (arg_valid) begin
                check("beat_expected", bq.size() > 0, 1);
                if (bq.size() > 0) begin
                    check("beat_data", arg_data & bq[0].mask, bq[0].data);
                    check("beat_count", arg_count, bq[0].cnt);
                    check("beat_last", arg_last, bq[0].last);
                end
            end
            if (done) begin
                last_done_cyc = cyc;
                if (!rnd) check("done_cycle", cyc, m_done_cyc);
                if (!rnd && m_done_cyc > 2) check("first_cmd_cycle", first_cmd, 2);
                check("error_at_done", error, m_err);
                check("cmds_left", cq.size(), 0);
                check("beats_left", bq.size(), 0);
                finished = 1'b1;
            end else begin
                check("busy", busy, 1);
            end
            cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            arg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!finished && abort_beat >= 0 && arg_valid && nbeat == abort_beat) begin
                go_abort = 1'b1;
                abort    = 1'b1;
                start    = 1'b0;
            end
            if (!go_abort) begin
                if (cmd_valid && cmd_ready && cq.size() > 0) void'(cq.pop_front());
                if (arg_valid && arg_ready && bq.size() > 0) begin
                    void'(bq.pop_front());
                    nbeat++;
                end
            end
            @(negedge clk);
            cyc++;
            if (go_abort) begin
                abort = 1'b0;
                check("abort_idle", busy, 0);
                check("abort_no_done", done, 0);
                check("abort_no_cmd", cmd_valid, 0);
                check("abort_no_arg", arg_valid, 0);
                finished = 1'b1;
            end
        end
        start     = 1'b0;
        cmd_ready = 1'b1;
        arg_ready = 1'b1;
        check("stream_finished", finished, 1);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 32'd0;
        cmd_ready = 1'b1;
        arg_ready = 1'b1;
        load_image();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_arg_valid", arg_valid, 0);
        check("rst_addr1", addr1, 0);
        check("rst_addr2", addr2, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Nominal image, readies held high.
        run_stream(0, 1'b0, -1);
        check("image_done_cycle", last_done_cyc, 28);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("idle_after_done", busy, 0);

        // Random backpressure and ignored mid-stream starts.
        repeat (3) begin
            load_image();
            run_stream(0, 1'b1, -1);
        end

        // Oversized argument count.
        mem[0] = 32'h8000_1411;
        run_stream(0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("argc_error_held", error, 1);

        // Argument block running past the end of memory.
        load_image();
        mem[41] = 32'h8000_0303;
        run_stream(41, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("bounds_error_held", error, 1);
        check("bounds_idle", busy, 0);

        load_image();
        run_stream(0, 1'b0, -1);

        // Abort during the second multmatrix beat, then a clean re-run.
        run_stream(0, 1'b0, 1);
        @(negedge clk);
        check("abort_still_no_done", done, 0);
        run_stream(0, 1'b0, -1);

        // Asynchronous reset while argument beats are being offered.
        @(negedge clk);
        base_addr = 32'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (arg_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("reached_args", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_arg_valid", arg_valid, 0);
        check("arst_arg_data", arg_data, 0);
        check("arst_arg_count", arg_count, 0);
        check("arst_arg_last", arg_last, 0);
        check("arst_cmd_valid", cmd_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr1", addr1, 0);
        check("arst_addr2", addr2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", busy, 0);
            check("post_rst_no_cmd", cmd_valid, 0);
        end
        load_image();
        run_stream(0, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
